// File: rtl/sm_sample_tx.sv
// Sample transmitter: buffers two's-complement samples in a small FIFO and emits them
// as sign-magnitude words framed by a square-wave strobe, flagging every 16th sample.
module sm_sample_tx #(
  parameter int HALF  = 5,
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       res,
  input  logic [7:0] din,
  input  logic       din_vld,
  output logic       din_rdy,
  output logic [7:0] data_out,
  output logic       syn_out,
  output logic       frame_out,
  output logic       busy
);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_HIGH, S_LOW} state_t;

  localparam logic [7:0] HIGH_LAST = 8'(HALF - 1);
  localparam logic [7:0] LOW_LAST  = 8'(HALF - 2);

  state_t     state, state_nx;
  logic [7:0] cnt, cnt_nx;
  logic [3:0] sample_idx;
  logic [7:0] mem [DEPTH];
  logic [2:0] wptr, rptr;
  logic       empty, full, push, pop;

  function automatic logic [7:0] to_sm(input logic [7:0] v);
    logic [7:0] neg;
    neg = ~v + 8'd1;
    if (!v[7])          return v;
    else if (v == 8'h80) return 8'hFF;
    else                return {1'b1, neg[6:0]};
  endfunction

  // The wrap bit distinguishes full from empty when the 2-bit addresses match.
  assign empty   = (wptr == rptr);
  assign full    = (wptr[1:0] == rptr[1:0]) && (wptr[2] != rptr[2]);
  assign din_rdy = !full;
  assign push    = din_vld && !full;
  assign busy    = (state != S_IDLE) || !empty;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_nx = state;
    cnt_nx   = cnt;
    pop      = 1'b0;
    case (state)
      S_IDLE: begin
        if (!empty) begin
          pop      = 1'b1;
          state_nx = S_SETUP;
        end
      end
      S_SETUP: begin
        cnt_nx   = '0;
        state_nx = S_HIGH;
      end
      S_HIGH: begin
        if (cnt == HIGH_LAST) begin
          cnt_nx   = '0;
          state_nx = S_LOW;
        end else begin
          cnt_nx = cnt + 8'd1;
        end
      end
      S_LOW: begin
        if (cnt == LOW_LAST) begin
          cnt_nx = '0;
          if (!empty) begin
            pop      = 1'b1;
            state_nx = S_SETUP;
          end else begin
            state_nx = S_IDLE;
          end
        end else begin
          cnt_nx = cnt + 8'd1;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // NOTE: all sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state      <= S_IDLE;
      cnt        <= '0;
      sample_idx <= '0;
      wptr       <= '0;
      rptr       <= '0;
      data_out   <= '0;
      syn_out    <= 1'b0;
      frame_out  <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      syn_out   <= (state_nx == S_HIGH);
      frame_out <= (state_nx == S_HIGH) && (sample_idx == 4'd15);
      if (state == S_HIGH && state_nx == S_LOW) sample_idx <= sample_idx + 4'd1;
      if (push) wptr <= wptr + 3'd1;
      if (pop) begin
        rptr     <= rptr + 3'd1;
        data_out <= to_sm(mem[rptr[1:0]]);
      end
    end
  end

  // NOTE: the storage array has no reset; resetting the pointers is enough to discard its contents.
  always_ff @(posedge clk) begin
    if (push) mem[wptr[1:0]] <= din;
  end

endmodule

// File: doc/sm_sample_tx.md
Name: sm_sample_tx

Overview:
- Transmit-side source for the 16-sample signed accumulator.
- Accepts 8-bit two's-complement samples through a valid/ready handshake and buffers them in a 4-entry FIFO.
- Converts each sample to 8-bit sign-magnitude and presents it on data_out with a square-wave syn_out strobe; the consumer captures data on each syn_out rising edge.
- Flags every 16th sample with frame_out so the consumer's 16-sample window can be aligned and checked.

Parameters:
- HALF, 5: clk cycles per syn_out phase; sample period is 2*HALF; legal range 2..255.
- DEPTH, 4: FIFO entries; fixed at 4, pointers are 2 bits plus wrap bit.

Ports:
- clk  input  1  system clock, all state on rising edge.
- res  input  1  reset, asynchronous, active-low; clears all state.
- din  input  8  sample, two's complement.
- din_vld  input  1  din valid.
- din_rdy  output  1  FIFO not full; a sample is accepted on a clk edge where din_vld & din_rdy.
- data_out  output  8  current sample, sign-magnitude (bit7 sign, bits6:0 magnitude).
- syn_out  output  1  sample strobe; rising edge marks a new valid data_out.
- frame_out  output  1  high with syn_out during the HIGH phase of sample index 15.
- busy  output  1  high when FSM is not IDLE or the FIFO is non-empty.

Behaviour:
- Reset values (res low, async): data_out=0, syn_out=0, frame_out=0, din_rdy=1, busy=0, FIFO empty, FSM=IDLE, sample index=0, phase counter=0.
- Conversion (combinational, applied at FIFO pop):
  - din[7]=0: data_out = din.
  - din = 0x80: data_out = 0xFF (saturate to -127; 0x80 is never emitted).
  - Otherwise: data_out = {1'b1, (~din+1)[6:0]}.
  - Examples: +1 -> 0x01, -1 -> 0x81, +127 -> 0x7F, -127 -> 0xFF, 0 -> 0x00.
- FSM states:
  - IDLE: syn_out=0. If FIFO is non-empty, go to SETUP next edge, popping the head entry and loading converted data_out on that same edge.
  - SETUP: exactly 1 cycle; syn_out=0; data_out is already stable. Go to HIGH.
  - HIGH: syn_out=1 for HALF cycles. frame_out = (sample index==15) for those same cycles. On exit, sample index increments mod 16 (15 wraps to 0). Go to LOW.
  - LOW: syn_out=0 for HALF-1 cycles. On the last LOW cycle: if FIFO is non-empty, pop, load data_out and go to SETUP; if empty, go to IDLE.
- Timing:
  - Back-to-back samples give a continuous square wave with period 2*HALF.
  - syn_out rises exactly 2 edges after a pop from IDLE.
  - data_out holds from SETUP until the next pop and does not change in IDLE.
  - syn_out and frame_out are registered outputs.
- FIFO:
  - din_rdy = !full, registered view of the current count.
  - A push while full cannot occur (din_rdy is low).
  - Simultaneous push and pop in one cycle leaves the count unchanged, with data order preserved.
  - A pop while empty cannot occur (guarded by the FSM).
  - Read and write pointers wrap modulo 4.
- Sample index counts emitted samples only; IDLE gaps do not reset it.
- Reset mid-operation (including mid-HIGH): syn_out drops immediately and all buffered samples are discarded.

Test Plan:
- Single sample: reset release, push din=0x01 once, HALF=5 -> syn_out rises 2 edges after the pop, stays high 5 cycles, data_out=0x01 throughout; then IDLE, busy=0.
- Sign conversion: push 0xFF, 0x80, 0x81, 0x7F, 0x00 -> data_out sequence 0x81, 0xFF, 0xFF, 0x7F, 0x00, one per syn_out rising edge.
- Frame and wrap: din_vld held high with din=0x01 for 32 samples -> syn_out period exactly 10 cycles with no gaps; frame_out high only in HIGH phases of samples 16 and 32; index wraps to 0.
- Backpressure: din_vld held high from reset release -> din_rdy drops once 4 entries are buffered, then accepts exactly one sample per 10 cycles; no sample lost or duplicated, order preserved.
- Reset mid-HIGH: assert res low during sample 3's HIGH phase with 2 entries queued -> syn_out=0 and data_out=0 immediately, din_rdy=1, busy=0; next pushed sample is emitted with frame index 0.
- Loopback: drive the accumulator consumer with 16 samples of 0xFF (two's complement -1) -> consumer sum equals 12'hFF0 (-16) after the frame.
